// File: rtl/tetris_input_ctrl.sv
// Button front end for tetris_logic: sync, debounce, edge detect, DAS auto-repeat
// and a single-issue arbiter producing one-cycle movement pulses.
module tetris_input_ctrl #(
  parameter int DB_CYC    = 8,
  parameter int DAS_DELAY = 12,
  parameter int DAS_RATE  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic E,
  input  logic btnL,
  input  logic btnR,
  input  logic btnD,
  input  logic btnU,
  input  logic btnC,
  output logic mvL,
  output logic mvR,
  output logic mvD,
  output logic mvRot,
  output logic mvDrop
);

  localparam logic [7:0] DB_MAX   = 8'(DB_CYC - 1);
  localparam logic [7:0] DLY_MAX  = 8'(DAS_DELAY - 1);
  localparam logic [7:0] RATE_MAX = 8'(DAS_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} das_t;

  // Bit order everywhere: 0=L, 1=R, 2=D, 3=U(rotate), 4=C(hard drop)
  logic [4:0] w_raw;
  logic [4:0] r_s1, r_s2;
  logic [4:0] r_deb, r_deb_d, r_sup;
  logic [7:0] r_dbc [5];
  logic [4:0] w_rise, w_press;

  das_t       r_das  [3];
  logic [7:0] r_dcnt [3];
  logic [2:0] w_rep;
  logic       w_both;

  logic [4:0] r_pend, w_set, w_iss, w_clr;

  assign w_raw   = {btnC, btnU, btnD, btnR, btnL};
  assign w_rise  = r_deb & ~r_deb_d;
  assign w_press = w_rise & ~r_sup;
  assign w_both  = r_deb[0] & r_deb[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // r_sup masks the first debounced rise after enable so a button already held
  // when E goes high never counts as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      r_sup   <= '0;
      for (int i = 0; i < 5; i++) r_dbc[i] <= '0;
    end else if (!E) begin
      r_deb   <= '0;
      r_deb_d <= '0;
      r_sup   <= '1;
      for (int i = 0; i < 5; i++) r_dbc[i] <= '0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 5; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_dbc[i] <= '0;
        end else if (r_dbc[i] == DB_MAX) begin
          r_deb[i] <= r_s2[i];
          r_dbc[i] <= '0;
        end else begin
          r_dbc[i] <= r_dbc[i] + 8'd1;
        end
        if (w_rise[i] || (!r_s2[i] && !r_deb[i])) r_sup[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rep = '0;
    for (int i = 0; i < 3; i++) begin
      if (r_deb[i] && !(i != 2 && w_both))
        w_rep[i] = (r_das[i] == DELAY  && r_dcnt[i] == DLY_MAX) ||
                   (r_das[i] == REPEAT && r_dcnt[i] == RATE_MAX);
    end
  end

  // DAS for L/R/D; simultaneous L+R parks both lateral machines in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        r_das[i]  <= IDLE;
        r_dcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!E || !r_deb[i] || (i != 2 && w_both)) begin
          r_das[i]  <= IDLE;
          r_dcnt[i] <= '0;
        end else begin
          case (r_das[i])
            IDLE: begin
              r_dcnt[i] <= '0;
              if (w_press[i]) r_das[i] <= DELAY;
            end
            DELAY: begin
              if (r_dcnt[i] == DLY_MAX) begin
                r_das[i]  <= REPEAT;
                r_dcnt[i] <= '0;
              end else begin
                r_dcnt[i] <= r_dcnt[i] + 8'd1;
              end
            end
            REPEAT: begin
              if (r_dcnt[i] == RATE_MAX) r_dcnt[i] <= '0;
              else                       r_dcnt[i] <= r_dcnt[i] + 8'd1;
            end
            default: begin
              r_das[i]  <= IDLE;
              r_dcnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  assign w_set = w_press | {2'b00, w_rep};

  // Priority Drop > D > L > R > Rot; a Drop issue also absorbs a pending D
  always_comb begin
    w_iss = '0;
    if      (r_pend[4]) w_iss[4] = 1'b1;
    else if (r_pend[2]) w_iss[2] = 1'b1;
    else if (r_pend[0]) w_iss[0] = 1'b1;
    else if (r_pend[1]) w_iss[1] = 1'b1;
    else if (r_pend[3]) w_iss[3] = 1'b1;
    w_clr    = w_iss;
    w_clr[2] = w_iss[2] | w_iss[4];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      mvL    <= 1'b0;
      mvR    <= 1'b0;
      mvD    <= 1'b0;
      mvRot  <= 1'b0;
      mvDrop <= 1'b0;
    end else if (!E) begin
      r_pend <= '0;
      mvL    <= 1'b0;
      mvR    <= 1'b0;
      mvD    <= 1'b0;
      mvRot  <= 1'b0;
      mvDrop <= 1'b0;
    end else begin
      r_pend <= (r_pend | w_set) & ~w_clr;
      mvL    <= w_iss[0];
      mvR    <= w_iss[1];
      mvD    <= w_iss[2] | w_iss[4];
      mvRot  <= w_iss[3];
      mvDrop <= w_iss[4];
    end
  end

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Bench for tetris_input_ctrl: table of single-shot press vectors plus hand
// sequences for DAS, enable and reset, checked against an expected-pulse queue.
module tb_tetris_input_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic E   = 1'b0;
  logic btnL = 1'b0, btnR = 1'b0, btnD = 1'b0, btnU = 1'b0, btnC = 1'b0;
  logic mvL, mvR, mvD, mvRot, mvDrop;

  // Button bits: 0=L 1=R 2=D 3=U 4=C. Output bits: 0=L 1=R 2=D 3=Rot 4=Drop.
  localparam logic [4:0] BL = 5'b00001, BR = 5'b00010, BD = 5'b00100,
                         BU = 5'b01000, BC = 5'b10000;
  localparam logic [4:0] OL = 5'b00001, OR = 5'b00010, OD = 5'b00100,
                         OROT = 5'b01000, ODROP = 5'b10100;

  tetris_input_ctrl #(.DB_CYC(8), .DAS_DELAY(12), .DAS_RATE(3)) dut (
    .clk(clk), .rst(rst), .E(E),
    .btnL(btnL), .btnR(btnR), .btnD(btnD), .btnU(btnU), .btnC(btnC),
    .mvL(mvL), .mvR(mvR), .mvD(mvD), .mvRot(mvRot), .mvDrop(mvDrop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string      name;
    logic [4:0] btn;
    int         hold;
    logic [4:0] e0;
    logic [4:0] e1;
  } vec_t;
  vec_t vt[12];

  int checks = 0;
  int failures = 0;
  logic [4:0] mon_o;

  always @(negedge clk) begin
    mon_o = {mvDrop, mvRot, mvD, mvR, mvL};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_pulse cyc=%0d actual=none required=%b", sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      checks++;
      if (mon_o !== sb[0].val) begin
        failures++;
        $display("FAIL pulse cyc=%0d actual=%b required=%b", cyc, mon_o, sb[0].val);
      end
      void'(sb.pop_front());
    end else if (mon_o !== 5'b0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse cyc=%0d actual=%b required=00000", cyc, mon_o);
    end
  end

  task automatic set_btns(input logic [4:0] b);
    {btnC, btnU, btnD, btnR, btnL} = b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s pending_pulses actual=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int t0;
    tick(1);
    t0 = cyc;
    if (v.e0 != 5'b0) push(t0 + 12, v.e0);
    if (v.e1 != 5'b0) push(t0 + 13, v.e1);
    set_btns(v.btn);
    tick(v.hold);
    set_btns(5'b0);
    tick(70 - v.hold);
    check_empty(v.name);
  endtask

  // Press pulse at +12, first repeat 12 later, then every 3 while deb is high
  task automatic das_seq(input string name, input logic [4:0] b, input logic [4:0] o, input int hold);
    int t0;
    tick(1);
    t0 = cyc;
    push(t0 + 12, o);
    for (int n = 24; n <= hold + 11; n += 3) push(t0 + n, o);
    set_btns(b);
    tick(hold);
    set_btns(5'b0);
    tick(40);
    check_empty(name);
  endtask

  initial begin
    vt[0]  = '{"glitch5_L",  BL,           5,  5'b0,  5'b0};
    vt[1]  = '{"glitch7_L",  BL,           7,  5'b0,  5'b0};
    vt[2]  = '{"edge8_L",    BL,           8,  OL,    5'b0};
    vt[3]  = '{"press_L",    BL,           10, OL,    5'b0};
    vt[4]  = '{"press_R",    BR,           10, OR,    5'b0};
    vt[5]  = '{"press_D",    BD,           10, OD,    5'b0};
    vt[6]  = '{"press_U",    BU,           10, OROT,  5'b0};
    vt[7]  = '{"press_C",    BC,           10, ODROP, 5'b0};
    vt[8]  = '{"contend_CDU", BC | BD | BU, 10, ODROP, OROT};
    vt[9]  = '{"hold_LR",    BL | BR,      40, OL,    OR};
    vt[10] = '{"contend_DU", BD | BU,      10, OD,    OROT};
    vt[11] = '{"contend_RU", BR | BU,      10, OR,    OROT};

    // Reset held while buttons toggle: outputs must stay low
    rst = 1'b0;
    E   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_btns(5'($urandom_range(0, 31)));
      @(negedge clk);
      checks++;
      if ({mvDrop, mvRot, mvD, mvR, mvL} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outs actual=%b required=00000", {mvDrop, mvRot, mvD, mvR, mvL});
      end
    end
    set_btns(5'b0);
    tick(1);
    rst = 1'b1;
    tick(30);
    check_empty("after_reset");

    for (int k = 0; k < 12; k++) run_vec(vt[k]);

    das_seq("das_R", BR, OR, 40);
    das_seq("das_D", BD, OD, 30);

    // Enable low while D held, then high with D still held: no pulse
    E = 1'b0;
    set_btns(BD);
    tick(30);
    E = 1'b1;
    tick(30);
    set_btns(5'b0);
    tick(30);
    check_empty("enable_held_D");
    run_vec('{"repress_D", BD, 10, OD, 5'b0});

    // Reset in the middle of auto-repeat kills all further repeats
    begin
      int t0;
      tick(1);
      t0 = cyc;
      push(t0 + 12, OR);
      push(t0 + 24, OR);
      push(t0 + 27, OR);
      push(t0 + 30, OR);
      set_btns(BR);
      tick(31);
      rst = 1'b0;
      set_btns(5'b0);
      tick(3);
      rst = 1'b1;
      tick(40);
      check_empty("reset_mid_das");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
